// File: rtl/flash_responder.sv
// flash_responder: Avalon-MM read-only responder standing in for the EPCS128 flash read port.
// Data is pattern-generated per byte lane; define FLASH_RESPONDER_BYTEMASK_EN to zero disabled lanes.

module flash_responder_lane #(
    parameter int         ADDR_WIDTH = 23,
    parameter int         LANE       = 0,
    parameter logic [7:0] SEED       = 8'h00,
    parameter bit         BYTEMASK   = 1'b0
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  be,
    output logic [7:0]            data
);
    localparam int SW = ADDR_WIDTH + 2;

    logic [7:0] gen;

    // Byte address {addr,2'b00}+lane; only the low 8 bits survive, so upper address bits fall away.
    assign gen  = 8'({addr, 2'b00} + SW'(LANE) + SW'(SEED));
    assign data = (BYTEMASK && !be) ? 8'h00 : gen;
endmodule

module flash_responder #(
    parameter int         ADDR_WIDTH   = 23,
    parameter int         WAIT_CYCLES  = 2,
    parameter int         READ_LATENCY = 3,
    parameter logic [7:0] SEED         = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    output logic [15:0]           rd_count,
    output logic                  protocol_err
);
    localparam int NUM_LANES = 4;
    localparam int CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
`ifdef FLASH_RESPONDER_BYTEMASK_EN
    localparam bit BYTEMASK = 1'b1;
`else
    localparam bit BYTEMASK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, STALL, ACCEPT} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [3:0]            be;
    } req_t;

    state_t                          state;
    logic [CW-1:0]                   cnt;
    logic                            accept;
    logic [READ_LATENCY:0]           vld_pipe;
    req_t [READ_LATENCY-1:0]         req_pipe;
    logic [NUM_LANES-1:0][7:0]       lane_data;

    assign accept = (state == ACCEPT) && read;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            waitrequest  <= 1'b1;
            rd_count     <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (read) begin
                        if (WAIT_CYCLES == 0) begin
                            state       <= ACCEPT;
                            waitrequest <= 1'b0;
                        end else begin
                            state <= STALL;
                            cnt   <= CW'(WAIT_CYCLES);
                        end
                    end
                end
                STALL: begin
                    // A master that withdraws a stalled read gets no response at all.
                    if (!read) begin
                        protocol_err <= 1'b1;
                        state        <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        state       <= ACCEPT;
                        waitrequest <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ACCEPT: begin
                    waitrequest <= 1'b1;
                    state       <= IDLE;
                    if (read) rd_count     <= rd_count + 16'd1;
                    else      protocol_err <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    waitrequest <= 1'b1;
                end
            endcase
        end
    end

    // One pipeline slot per cycle of latency; slot i belongs to the read accepted i cycles ago.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe <= '0;
            req_pipe <= '0;
            readdata <= '0;
        end else begin
            vld_pipe <= {vld_pipe[READ_LATENCY-1:0], accept};
            if (accept) begin
                req_pipe[0].addr <= address;
                req_pipe[0].be   <= byteenable;
            end
            for (int i = READ_LATENCY - 1; i > 0; i--) req_pipe[i] <= req_pipe[i-1];
            if (vld_pipe[READ_LATENCY-1]) readdata <= lane_data;
        end
    end

    assign readdatavalid = vld_pipe[READ_LATENCY];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        flash_responder_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LANE       (g),
            .SEED       (SEED),
            .BYTEMASK   (BYTEMASK)
        ) u_lane (
            .addr (req_pipe[READ_LATENCY-1].addr),
            .be   (req_pipe[READ_LATENCY-1].be[g]),
            .data (lane_data[g])
        );
    end
endmodule

// File: tb/tb_flash_responder.sv
// Self-checking bench for flash_responder: two configurations, random master traffic, elapsed-cycle model.
// Honours FLASH_RESPONDER_BYTEMASK_EN the same way the design does.

module tb_flash_responder;
`ifdef FLASH_RESPONDER_BYTEMASK_EN
    localparam bit MASK = 1'b1;
`else
    localparam bit MASK = 1'b0;
`endif

    typedef struct packed {
        logic [22:0] a;
        logic [3:0]  be;
        logic [7:0]  drop;
        logic [7:0]  gap;
    } cmd_t;

    typedef struct packed {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] @%0t: got %h, expected %h", nm, k, $time, act, exp);
        end
    endtask

    // byte n of word A = (4*A + n + seed) mod 256
    function automatic logic [31:0] gen(input logic [22:0] a, input logic [3:0] be, input logic [7:0] s);
        logic [31:0] w;
        int          v;
        w = '0;
        for (int n = 0; n < 4; n++) begin
            v = ((int'(a) % 64) * 4 + n + int'(s)) % 256;
            if (MASK && !be[n]) v = 0;
            w[8*n +: 8] = 8'(v);
        end
        return w;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_cfg
        localparam int         W = (k == 0) ? 2 : 0;
        localparam int         L = (k == 0) ? 3 : 1;
        localparam logic [7:0] S = (k == 0) ? 8'h00 : 8'hFE;

        logic        read, wr, rdv, perr, wr_s, busy;
        logic [22:0] address;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [15:0] cnt;
        cmd_t        cq[$];
        rsp_t        mq[$];
        int          acc_n;
        int          since, cycn;
        logic        e_wr, e_rdv, e_perr;
        logic [31:0] e_rd;
        logic [15:0] e_cnt;

        flash_responder #(
            .ADDR_WIDTH   (23),
            .WAIT_CYCLES  (W),
            .READ_LATENCY (L),
            .SEED         (S)
        ) dut (
            .clk           (clk),
            .reset         (rst_n),
            .address       (address),
            .read          (read),
            .byteenable    (be),
            .waitrequest   (wr),
            .readdata      (rdata),
            .readdatavalid (rdv),
            .rd_count      (cnt),
            .protocol_err  (perr)
        );

        initial forever begin
            @(negedge clk);
            wr_s = wr;
        end

        // Master: holds read until accepted, or withdraws it after `drop` cycles when drop != 0.
        initial begin
            cmd_t c;
            int   held, gapc;
            logic ended;
            read = 1'b0; address = '0; be = '0; busy = 1'b0; acc_n = 0;
            held = 0; gapc = 0; c = '0;
            forever begin
                @(posedge clk);
                #2;
                ended = 1'b0;
                if (!rst_n) begin
                    read = 1'b0;
                    busy = 1'b0;
                end else if (busy) begin
                    if (read && !wr_s) begin
                        read = 1'b0;
                        busy = 1'b0;
                        acc_n++;
                    end else begin
                        held++;
                        if (c.drop != 0 && held >= int'(c.drop)) begin
                            read  = 1'b0;
                            busy  = 1'b0;
                            ended = 1'b1;
                        end
                    end
                end
                if (rst_n && !busy && !ended && cq.size() != 0) begin
                    if (gapc < int'(cq[0].gap)) gapc++;
                    else begin
                        c = cq.pop_front();
                        gapc = 0; held = 0;
                        read = 1'b1; address = c.a; be = c.be; busy = 1'b1;
                    end
                end
            end
        end

        // Model: count cycles since a read was first seen; the accept cycle is cycle W+1.
        initial begin
            rsp_t r;
            since = 0; cycn = 0; e_cnt = '0; e_wr = 1'b1; e_rdv = 1'b0; e_perr = 1'b0; e_rd = '0;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    since = 0; mq.delete();
                    e_wr = 1'b1; e_rdv = 1'b0; e_perr = 1'b0; e_rd = '0; e_cnt = '0;
                end else begin
                    cycn++;
                    e_rdv = 1'b0;
                    if (mq.size() != 0 && mq[0].due == cycn) begin
                        e_rdv = 1'b1;
                        e_rd  = mq[0].data;
                        void'(mq.pop_front());
                    end
                    if (since == 0) begin
                        if (read) since = 1;
                    end else if (since <= W) begin
                        if (read) since++;
                        else begin
                            e_perr = 1'b1;
                            since  = 0;
                        end
                    end else begin
                        if (read) begin
                            e_cnt++;
                            r.due  = cycn + L;
                            r.data = gen(address, be, S);
                            mq.push_back(r);
                        end else e_perr = 1'b1;
                        since = 0;
                    end
                    e_wr = (since != W + 1);
                    chk("pipe_depth", k, 32'(mq.size() <= L), 32'd1);
                end
            end
        end

        initial forever begin
            @(negedge clk);
            chk("waitrequest", k, 32'(wr), 32'(e_wr));
            chk("readdatavalid", k, 32'(rdv), 32'(e_rdv));
            chk("readdata", k, rdata, e_rd);
            chk("rd_count", k, 32'(cnt), 32'(e_cnt));
            chk("protocol_err", k, 32'(perr), 32'(e_perr));
        end
    end

    task automatic push(input int k, input logic [22:0] a, input logic [3:0] b, input int drop, input int gap);
        cmd_t c;
        c.a = a; c.be = b; c.drop = 8'(drop); c.gap = 8'(gap);
        case (k)
            0:       g_cfg[0].cq.push_back(c);
            default: g_cfg[1].cq.push_back(c);
        endcase
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        while ((g_cfg[0].busy || g_cfg[0].cq.size() != 0 || g_cfg[0].mq.size() != 0 ||
                g_cfg[1].busy || g_cfg[1].cq.size() != 0 || g_cfg[1].mq.size() != 0) && n < limit) begin
            @(posedge clk);
            n++;
        end
        chk("idle_timeout", 0, 32'(n < limit), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n0;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        push(0, 23'd100, 4'hF, 0, 0);
        push(1, 23'd0, 4'hF, 0, 0);
        wait_idle(200);
        chk("t1_rdata", 0, g_cfg[0].rdata, 32'h93929190);
        chk("t1_model", 0, g_cfg[0].e_rd, 32'h93929190);
        chk("t1_count", 0, 32'(g_cfg[0].cnt), 32'd1);
        chk("seed_wrap", 1, g_cfg[1].rdata, 32'h0100FFFE);
        chk("seed_model", 1, g_cfg[1].e_rd, 32'h0100FFFE);

        push(0, 23'd637, 4'hF, 0, 0);
        push(0, 23'd638, 4'hF, 0, 0);
        wait_idle(200);
        chk("b2b_rdata", 0, g_cfg[0].rdata, 32'hFBFAF9F8);
        chk("b2b_count", 0, 32'(g_cfg[0].cnt), 32'd3);

        push(0, 23'd5, 4'hF, 1, 0);
        wait_idle(200);
        chk("drop_perr", 0, 32'(g_cfg[0].perr), 32'd1);
        chk("drop_count", 0, 32'(g_cfg[0].cnt), 32'd3);
        push(0, 23'd6, 4'hF, 0, 0);
        wait_idle(200);
        chk("after_drop_rdata", 0, g_cfg[0].rdata, 32'h1B1A1918);
        chk("after_drop_count", 0, 32'(g_cfg[0].cnt), 32'd4);
        chk("perr_sticky", 0, 32'(g_cfg[0].perr), 32'd1);

        push(0, 23'd101, 4'b0101, 0, 0);
        wait_idle(200);
        chk("bytemask", 0, g_cfg[0].rdata, MASK ? 32'h00960094 : 32'h97969594);

        n0 = g_cfg[0].acc_n;
        push(0, 23'd100, 4'hF, 0, 0);
        for (int i = 0; i < 50 && g_cfg[0].acc_n == n0; i++) begin
            @(posedge clk);
            #3;
        end
        chk("rst_accepted", 0, 32'(g_cfg[0].acc_n != n0), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rst_rdv", 0, 32'(g_cfg[0].rdv), 32'd0);
        end
        chk("rst_count", 0, 32'(g_cfg[0].cnt), 32'd0);
        chk("rst_perr", 0, 32'(g_cfg[0].perr), 32'd0);
        chk("rst_rdata", 0, g_cfg[0].rdata, 32'd0);
        chk("rst_wait", 0, 32'(g_cfg[0].wr), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            push(i % 2, 23'($urandom), 4'($urandom),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0,
                 $urandom_range(0, 3));
        end
        wait_idle(5000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
